// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pkg
//  Description : Shared constants and helpers for the GPIO input
//                conditioning stage (register map, reset values, defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    // Default widths of the threshold/pin counter and of the prescaler
    localparam int GPIO_DB_CNT_W_DEF   = 4;
    localparam int GPIO_DB_PRESC_W_DEF = 16;

    // Register word indices, decoded from byte address bits [3:2]
    localparam logic [1:0] GPIO_DB_PRESC  = 2'd0;
    localparam logic [1:0] GPIO_DB_THRESH = 2'd1;
    localparam logic [1:0] GPIO_DB_FEN    = 2'd2;
    localparam logic [1:0] GPIO_DB_RAW    = 2'd3;

    // Reset values of the software-visible registers
    localparam logic [31:0] GPIO_DB_PRESC_RST  = 32'd0;
    localparam logic [31:0] GPIO_DB_THRESH_RST = 32'd3;
    localparam logic [31:0] GPIO_DB_FEN_RST    = 32'd0;

    // Merge a write word into an existing value, one byte lane at a time
    function automatic logic [31:0] gpio_db_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_debounce_cell.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce_cell
//  Description : Single-pin debounce filter. Accepts a new synchronised value
//                only after thr consecutive ticks of disagreement, or passes
//                the input straight through when filtering is disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce_cell
    import gpio_pkg::*;
#(
    parameter int CNT_W = GPIO_DB_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             tick,
    input  logic             fen,
    input  logic [CNT_W-1:0] thr,
    output logic             out_q
);

    logic             r_out_q;
    logic [CNT_W-1:0] r_cnt;

    // Filter state: agreement clears the count, disagreement counts ticks
    // and the >= compare keeps a lowered threshold from overrunning
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q <= 1'b0;
            r_cnt   <= '0;
        end else if (!fen) begin
            r_out_q <= sync;
            r_cnt   <= '0;
        end else if (sync == r_out_q) begin
            r_cnt   <= '0;
        end else if (tick) begin
            if (r_cnt >= (thr - CNT_W'(1))) begin
                r_out_q <= sync;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_q = r_out_q;

endmodule : gpio_debounce_cell
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce
//  Description : Pad input conditioning in front of the GPIO controller:
//                two-flop synchroniser, shared tick prescaler and per-pin
//                debounce filters, configured over a Wishbone slave port.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int NO_OF_GPIO_PINS = 32,
    parameter int CNT_W           = GPIO_DB_CNT_W_DEF,
    parameter int PRESC_W         = GPIO_DB_PRESC_W_DEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [3:0]                 wb_adr_i,
    input  logic [31:0]                wb_dat_i,
    input  logic [3:0]                 wb_sel_i,
    output logic [31:0]                wb_dat_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    input  logic [NO_OF_GPIO_PINS-1:0] pad_i,
    output logic [NO_OF_GPIO_PINS-1:0] gpio_o,
    output logic [NO_OF_GPIO_PINS-1:0] chg_o
);

    logic                       r_ack;
    logic [PRESC_W-1:0]         r_presc;
    logic [PRESC_W-1:0]         r_presc_cnt;
    logic [CNT_W-1:0]           r_thresh;
    logic [NO_OF_GPIO_PINS-1:0] r_fen;
    logic [NO_OF_GPIO_PINS-1:0] r_sync0;
    logic [NO_OF_GPIO_PINS-1:0] r_sync1;
    logic [NO_OF_GPIO_PINS-1:0] r_out_q_d;
    logic [NO_OF_GPIO_PINS-1:0] w_out_q;

    logic                       w_acc;
    logic                       w_wr;
    logic [1:0]                 w_reg_sel;
    logic                       w_wr_presc;
    logic                       w_wr_thresh;
    logic                       w_wr_fen;
    logic [PRESC_W-1:0]         w_presc_new;
    logic [CNT_W-1:0]           w_thresh_new;
    logic [NO_OF_GPIO_PINS-1:0] w_fen_new;
    logic [CNT_W-1:0]           w_thr;
    logic                       w_tick;
    logic                       w_unused;

    // Byte-offset bits below the word index carry no information
    assign w_unused = ^wb_adr_i[1:0];

    // A new access is accepted only while no ack is outstanding, so held
    // strobes alternate and every access is acked exactly once
    assign w_acc       = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr        = w_acc & wb_we_i;
    assign w_reg_sel   = wb_adr_i[3:2];
    assign w_wr_presc  = w_wr && (w_reg_sel == GPIO_DB_PRESC);
    assign w_wr_thresh = w_wr && (w_reg_sel == GPIO_DB_THRESH);
    assign w_wr_fen    = w_wr && (w_reg_sel == GPIO_DB_FEN);

    assign w_presc_new  = PRESC_W'(gpio_db_merge(32'(r_presc), wb_dat_i, wb_sel_i));
    assign w_thresh_new = CNT_W'(gpio_db_merge(32'(r_thresh), wb_dat_i, wb_sel_i));
    assign w_fen_new    = NO_OF_GPIO_PINS'(gpio_db_merge(32'(r_fen), wb_dat_i, wb_sel_i));

    // A zero threshold behaves as one tick
    assign w_thr  = (r_thresh == '0) ? CNT_W'(1) : r_thresh;
    assign w_tick = (r_presc_cnt == '0);

    // Wishbone acknowledge, one cycle after the strobe
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_acc;
        end
    end

    // Configuration registers, written on the edge that raises the ack
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_presc  <= PRESC_W'(GPIO_DB_PRESC_RST);
            r_thresh <= CNT_W'(GPIO_DB_THRESH_RST);
            r_fen    <= NO_OF_GPIO_PINS'(GPIO_DB_FEN_RST);
        end else begin
            if (w_wr_presc) begin
                r_presc <= w_presc_new;
            end
            if (w_wr_thresh) begin
                r_thresh <= w_thresh_new;
            end
            if (w_wr_fen) begin
                r_fen <= w_fen_new;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous pads
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
        end else begin
            r_sync0 <= pad_i;
            r_sync1 <= r_sync0;
        end
    end

    // Tick prescaler: down-counter, restarted immediately by a PRESC write
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_presc_cnt <= '0;
        end else if (w_wr_presc) begin
            r_presc_cnt <= w_presc_new;
        end else if (w_tick) begin
            r_presc_cnt <= r_presc;
        end else begin
            r_presc_cnt <= r_presc_cnt - PRESC_W'(1);
        end
    end

    // Delayed copy of the filtered outputs for change detection
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_out_q_d <= '0;
        end else begin
            r_out_q_d <= w_out_q;
        end
    end

    // Combinational register readback; unused bits read as zero
    always_comb begin
        wb_dat_o = 32'd0;
        case (w_reg_sel)
            GPIO_DB_PRESC:  wb_dat_o = 32'(r_presc);
            GPIO_DB_THRESH: wb_dat_o = 32'(r_thresh);
            GPIO_DB_FEN:    wb_dat_o = 32'(r_fen);
            GPIO_DB_RAW:    wb_dat_o = 32'(r_sync1);
            default:        wb_dat_o = 32'd0;
        endcase
    end

    for (genvar gi = 0; gi < NO_OF_GPIO_PINS; gi++) begin : g_pin
        gpio_debounce_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk   (wb_clk_i),
            .rst   (wb_rst_i),
            .sync  (r_sync1[gi]),
            .tick  (w_tick),
            .fen   (r_fen[gi]),
            .thr   (w_thr),
            .out_q (w_out_q[gi])
        );
    end

    assign wb_ack_o = r_ack;
    assign wb_err_o = 1'b0;
    assign gpio_o   = w_out_q;
    assign chg_o    = w_out_q ^ r_out_q_d;

endmodule : gpio_debounce
`default_nettype wire
